// File: rtl/wave_gen_processor_pkg.sv
// rtl/wave_gen_processor_pkg.sv - shared width, waveform select encodings and sine table size
package wave_gen_processor_pkg;

  localparam int W = 8;
  localparam int SINE_TABLE_SIZE = 65;

  typedef enum logic [2:0] {
    SEL_RECIP    = 3'b000,
    SEL_SQUARE   = 3'b001,
    SEL_TRI      = 3'b010,
    SEL_SAW      = 3'b011,
    SEL_SINE     = 3'b100,
    SEL_FULLRECT = 3'b101,
    SEL_HALFRECT = 3'b110,
    SEL_ZERO     = 3'b111
  } wave_sel_e;

endpackage

// File: rtl/wave_gen_processor_sine_rom.sv
// rtl/wave_gen_processor_sine_rom.sv - quarter-wave sine magnitude table with quadrant mirroring
module wave_sine_rom
  import wave_gen_processor_pkg::*;
(
  input  logic [7:0] cnt,
  output logic [7:0] mag
);

  logic [6:0] idx;

  // Odd quadrants walk the quarter table backwards, so index 64 is reachable.
  always_comb begin
    idx = cnt[6] ? (7'd64 - {1'b0, cnt[5:0]}) : {1'b0, cnt[5:0]};
  end

  always_comb begin
    mag = 8'd0;
    case (idx)
      7'd0:  mag = 8'd0;    7'd1:  mag = 8'd6;    7'd2:  mag = 8'd13;   7'd3:  mag = 8'd19;
      7'd4:  mag = 8'd25;   7'd5:  mag = 8'd31;   7'd6:  mag = 8'd37;   7'd7:  mag = 8'd44;
      7'd8:  mag = 8'd50;   7'd9:  mag = 8'd56;   7'd10: mag = 8'd62;   7'd11: mag = 8'd68;
      7'd12: mag = 8'd74;   7'd13: mag = 8'd80;   7'd14: mag = 8'd86;   7'd15: mag = 8'd92;
      7'd16: mag = 8'd98;   7'd17: mag = 8'd103;  7'd18: mag = 8'd109;  7'd19: mag = 8'd115;
      7'd20: mag = 8'd120;  7'd21: mag = 8'd126;  7'd22: mag = 8'd131;  7'd23: mag = 8'd136;
      7'd24: mag = 8'd142;  7'd25: mag = 8'd147;  7'd26: mag = 8'd152;  7'd27: mag = 8'd157;
      7'd28: mag = 8'd162;  7'd29: mag = 8'd167;  7'd30: mag = 8'd171;  7'd31: mag = 8'd176;
      7'd32: mag = 8'd180;  7'd33: mag = 8'd185;  7'd34: mag = 8'd189;  7'd35: mag = 8'd193;
      7'd36: mag = 8'd197;  7'd37: mag = 8'd201;  7'd38: mag = 8'd205;  7'd39: mag = 8'd208;
      7'd40: mag = 8'd212;  7'd41: mag = 8'd215;  7'd42: mag = 8'd219;  7'd43: mag = 8'd222;
      7'd44: mag = 8'd225;  7'd45: mag = 8'd228;  7'd46: mag = 8'd231;  7'd47: mag = 8'd233;
      7'd48: mag = 8'd236;  7'd49: mag = 8'd238;  7'd50: mag = 8'd240;  7'd51: mag = 8'd242;
      7'd52: mag = 8'd244;  7'd53: mag = 8'd246;  7'd54: mag = 8'd247;  7'd55: mag = 8'd249;
      7'd56: mag = 8'd250;  7'd57: mag = 8'd251;  7'd58: mag = 8'd252;  7'd59: mag = 8'd253;
      7'd60: mag = 8'd254;  7'd61: mag = 8'd254;  7'd62: mag = 8'd255;  7'd63: mag = 8'd255;
      7'd64: mag = 8'd255;
      default: mag = 8'd0;
    endcase
  end

endmodule

// File: rtl/wave_gen_processor.sv
// rtl/wave_gen_processor.sv - selectable periodic waveform generator driven by an external phase count
module wave_gen_processor
  import wave_gen_processor_pkg::*;
#(
  parameter int W = wave_gen_processor_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   slc,
  input  logic [W-1:0] cnt,
  output logic [W-1:0] out
);

  logic [W-1:0] out_q, out_d;
  logic [7:0]   mag;
  logic [8:0]   divisor;
  logic [8:0]   quotient;
  logic [7:0]   tri_d;
  logic [7:0]   half_mag;

  wave_sine_rom u_sine_rom (
    .cnt (cnt),
    .mag (mag)
  );

  // Nine-bit divisor keeps cnt=255 from wrapping to a divide by zero.
  always_comb begin
    divisor  = {1'b0, cnt} + 9'd1;
    quotient = 9'd255 / divisor;
    tri_d    = {cnt[6:0], 1'b0};
    half_mag = {1'b0, mag[7:1]};
  end

  always_comb begin
    out_d = '0;
    case (wave_sel_e'(slc))
      SEL_RECIP:    out_d = quotient[7:0];
      SEL_SQUARE:   out_d = cnt[7] ? 8'd255 : 8'd0;
      SEL_TRI:      out_d = cnt[7] ? (8'd255 - tri_d) : tri_d;
      SEL_SAW:      out_d = cnt;
      SEL_SINE:     out_d = cnt[7] ? (8'd128 - half_mag) : (8'd128 + half_mag);
      SEL_FULLRECT: out_d = mag;
      SEL_HALFRECT: out_d = cnt[7] ? 8'd0 : mag;
      SEL_ZERO:     out_d = '0;
      default:      out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_wave_gen_processor.sv
// tb/tb_wave_gen_processor.sv - randomized self-checking bench for wave_gen_processor
module tb_wave_gen_processor;

  logic       clk;
  logic       rst;
  logic [2:0] slc;
  logic [7:0] cnt;
  logic [7:0] out;

  int tests_run = 0;
  int fails = 0;

  wave_gen_processor #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .slc (slc),
    .cnt (cnt),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference waveform straight from the defining formulas, sine via real math.
  function automatic int ref_f(input int sel, input int c);
    real s;
    int  m;
    s = $sin(2.0 * 3.14159265358979323846 * c / 256.0);
    if (s < 0.0) s = -s;
    m = $rtoi(255.0 * s + 0.5);
    case (sel)
      0: return 255 / (c + 1);
      1: return (c < 128) ? 0 : 255;
      2: return (c < 128) ? 2 * (c % 128) : 255 - 2 * (c % 128);
      3: return c;
      4: return (c < 128) ? 128 + m / 2 : 128 - m / 2;
      5: return m;
      6: return (c < 128) ? m : 0;
      default: return 0;
    endcase
  endfunction

  task automatic apply(input int s, input int c);
    @(negedge clk);
    slc = s[2:0];
    cnt = c[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    slc = 3'd3;
    cnt = 8'd77;
    #2;
    tests_run++;
    if (out !== 8'd0) begin
      fails++;
      $display("FAIL reset_initial got %0d want 0", out);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out !== 8'd0) begin
      fails++;
      $display("FAIL reset_held got %0d want 0", out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out !== 8'd77) begin
      fails++;
      $display("FAIL reset_release got %0d want 77", out);
    end
  endtask

  task automatic test_recip;
    int cs[5] = '{0, 1, 3, 254, 255};
    int ex[5] = '{255, 127, 63, 1, 0};
    for (int i = 0; i < 5; i++) begin
      apply(0, cs[i]);
      tests_run++;
      if (out !== ex[i][7:0]) begin
        fails++;
        $display("FAIL recip cnt=%0d got %0d want %0d", cs[i], out, ex[i]);
      end
    end
  endtask

  task automatic test_square_sweep;
    for (int c = 0; c < 256; c++) begin
      apply(1, c);
      tests_run++;
      if (out !== ((c < 128) ? 8'd0 : 8'd255)) begin
        fails++;
        $display("FAIL square cnt=%0d got %0d", c, out);
      end
    end
  endtask

  task automatic test_sine_points;
    int cs[5] = '{0, 32, 64, 128, 192};
    int ex[5] = '{128, 218, 255, 128, 1};
    for (int i = 0; i < 5; i++) begin
      apply(4, cs[i]);
      tests_run++;
      if (out !== ex[i][7:0]) begin
        fails++;
        $display("FAIL sine cnt=%0d got %0d want %0d", cs[i], out, ex[i]);
      end
    end
  endtask

  task automatic test_rect_points;
    int cs[3]  = '{32, 160, 64};
    int exf[3] = '{180, 180, 255};
    int exh[3] = '{180, 0, 255};
    for (int i = 0; i < 3; i++) begin
      apply(5, cs[i]);
      tests_run++;
      if (out !== exf[i][7:0]) begin
        fails++;
        $display("FAIL fullrect cnt=%0d got %0d want %0d", cs[i], out, exf[i]);
      end
      apply(6, cs[i]);
      tests_run++;
      if (out !== exh[i][7:0]) begin
        fails++;
        $display("FAIL halfrect cnt=%0d got %0d want %0d", cs[i], out, exh[i]);
      end
    end
  endtask

  task automatic test_triangle_points;
    int cs[4] = '{127, 128, 255, 0};
    int ex[4] = '{254, 255, 1, 0};
    for (int i = 0; i < 4; i++) begin
      apply(2, cs[i]);
      tests_run++;
      if (out !== ex[i][7:0]) begin
        fails++;
        $display("FAIL triangle cnt=%0d got %0d want %0d", cs[i], out, ex[i]);
      end
    end
  endtask

  task automatic test_sequence;
    int seq[7] = '{1, 3, 4, 5, 2, 6, 0};
    int c = int'($urandom_range(0, 255));
    int bad = 0;
    for (int k = 0; k < 7; k++) begin
      for (int n = 0; n < 2560; n++) begin
        apply(seq[k], c);
        tests_run++;
        if (out !== ref_f(seq[k], c)) begin
          fails++;
          if (bad < 10)
            $display("FAIL sequence sel=%0d cnt=%0d got %0d want %0d", seq[k], c, out, ref_f(seq[k], c));
          bad++;
        end
        c = (c + 1) % 256;
      end
    end
  endtask

  task automatic test_random;
    int bad = 0;
    for (int n = 0; n < 3000; n++) begin
      int s = int'($urandom_range(0, 7));
      int c = int'($urandom_range(0, 255));
      apply(s, c);
      tests_run++;
      if (out !== ref_f(s, c)) begin
        fails++;
        if (bad < 10)
          $display("FAIL random sel=%0d cnt=%0d got %0d want %0d", s, c, out, ref_f(s, c));
        bad++;
      end
    end
  endtask

  task automatic test_async_reset;
    apply(1, 200);
    tests_run++;
    if (out !== 8'd255) begin
      fails++;
      $display("FAIL async_pre got %0d want 255", out);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (out !== 8'd0) begin
      fails++;
      $display("FAIL async_clear got %0d want 0", out);
    end
    @(negedge clk);
    slc = 3'd3;
    cnt = 8'd91;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out !== 8'd91) begin
      fails++;
      $display("FAIL async_recover got %0d want 91", out);
    end
  endtask

  initial begin
    test_reset();
    test_recip();
    test_square_sweep();
    test_triangle_points();
    test_sine_points();
    test_rect_points();
    test_sequence();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/wave_gen_processor.md
WAVE_GEN_PROCESSOR -- requirements
Module: wave_gen_processor

Interface
REQ-001 Parameter W, default 8, sample and phase width; only W=8 is required and verified.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 slc  input  3  waveform select; may change at any cycle.
REQ-005 cnt  input  8  phase from the external free-running 8-bit counter; one period = 256 counts.
REQ-006 out  output 8  unsigned waveform sample, registered.

Function
REQ-007 The block SHALL register out on every rising clk: out(n+1) = f(slc(n), cnt(n)); latency exactly 1 cycle, no enable.
REQ-008 slc=000, reciprocal: f = floor(255 / (cnt+1)); cnt=0 -> 255, cnt=255 -> 0.
REQ-009 slc=001, square: f = 0 for cnt<128, 255 for cnt>=128.
REQ-010 slc=010, triangle: with d = {cnt[6:0],0}: f = d for cnt<128, 255-d for cnt>=128; cnt=127 -> 254, 128 -> 255, 255 -> 1.
REQ-011 slc=011, sawtooth: f = cnt.
REQ-012 Quarter table T[i] = round(255*sin(2*pi*i/256)), i=0..64; T[0]=0, T[32]=180, T[64]=255.
REQ-013 Table lookup: p=cnt[5:0], quadrant q=cnt[7:6]; mag = T[p] for q in {0,2}, T[64-p] for q in {1,3}.
REQ-014 slc=100, sine: f = 128 + floor(mag/2) for cnt<128, 128 - floor(mag/2) for cnt>=128; range 1..255, cnt=0 -> 128.
REQ-015 slc=101, full-wave rectified sine: f = mag for all cnt.
REQ-016 slc=110, half-wave rectified sine: f = mag for cnt<128, 0 for cnt>=128.
REQ-017 slc=111: f = 0.
REQ-018 All arithmetic unsigned, no overflow; 8-bit divide by (cnt+1) uses a 9-bit divisor so cnt=255 does not wrap to 0.
REQ-019 A slc change takes effect on the next rising edge; no intermediate or blended value is ever output.
REQ-020 cnt wrap 255->0 SHALL produce continuous periodic output with no extra latency.

Reset
REQ-021 While rst=0, out SHALL be 0 immediately and asynchronously, regardless of clk.
REQ-022 Reset deasserted SHALL take effect synchronously; the first rising edge after release loads f(slc,cnt).
REQ-023 Reset asserted mid-period clears out; no other state exists, so recovery is immediate.

Structure
REQ-024 Shared package SHALL hold W, the slc encodings (RECIP=000, SQUARE=001, TRI=010, SAW=011, SINE=100, FULLRECT=101, HALFRECT=110, ZERO=111) and table size 65.
REQ-025 One sub-module, wave_sine_rom: combinational 65-entry quarter-wave table plus quadrant mirroring (REQ-012/013), input cnt, output mag.
REQ-026 Phase counter is external (existing 8-bit counter, en=1, clr=0, load=0); this block contains no phase counter.
REQ-027 Output mux is combinational case on slc, feeding a single 8-bit output register.

Verification
REQ-028 rst=0 pulse mid-run -> out=0 within the pulse without clk edge; after release, first edge gives f(slc,cnt).
REQ-029 slc=001, cnt sweep 0..255 -> out 0 at cnt=127, 255 at cnt=128, one cycle after cnt.
REQ-030 slc=000: cnt=0,1,3,254,255 -> out 255,127,63,1,0.
REQ-031 slc=100: cnt=0,32,64,128,192 -> out 128,218,255,128,1.
REQ-032 slc=101/110: cnt=32 -> 180/180; cnt=160 -> 180/0; cnt=64 -> 255/255.
REQ-033 Full sequence 001,011,100,101,010,110,000 with 2560 cycles each against a reference model -> every sample matches, slc switch visible exactly 1 cycle later.
